generic_spi_slave: RTL and testbench

Full-duplex SPI slave (responder) for the same four-wire bus driven by the generic SPI master. It oversamples SCLK, SS and MOSI with the system clock. It shifts a WordLen-bit word in from MOSI while shifting SendData out on MISO, in any of the four CPOL/CPHA modes and in either bit order. Each completed word is presented on ReceivedData with a one-cycle WordFlg strobe. It sits on the peripheral side of the bus, opposite the master.

---
 rtl/generic_spi_slave.sv | 191 +++++++++++++++++++
 tb/tb_generic_spi_slave.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/generic_spi_slave.sv
// Full-duplex SPI slave: oversampled SCLK/SS/MOSI, any CPOL/CPHA mode, MSB- or LSB-first.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN releases MISO (1'bz) whenever the slave is idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | SS high; bit counter cleared, MISO released/low
// ST_SHIFT | SS low; words shift in/out back-to-back until SS rises
module generic_spi_slave #(
    parameter int WordLen    = 8,
    parameter int SyncStages = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CPOL,
    input  logic               CPHA,
    input  logic               BitOrder,
    input  logic               SCLK,
    input  logic               SS,
    input  logic               MOSI,
    output logic               MISO,
    input  logic [WordLen-1:0] SendData,
    output logic [WordLen-1:0] ReceivedData,
    output logic               WordFlg,
    output logic               RxBusy,
    output logic               TxBusy
);

    localparam int CntW = $clog2(WordLen + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SyncStages-1:0] sclk_sync_q;
    logic [SyncStages-1:0] ss_sync_q;
    logic [SyncStages-1:0] mosi_sync_q;
    logic                  sclk_prev_q;
    logic                  ss_prev_q;

    logic                  cpol_q;
    logic                  cpha_q;
    logic                  order_q;

    logic [WordLen-1:0]    tx_q;
    logic [WordLen-1:0]    rx_q;
    logic [WordLen-1:0]    rdata_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic                  miso_q;
    logic                  flg_q;

    logic                  sclk_s;
    logic                  ss_s;
    logic                  mosi_s;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  ss_fall;
    logic                  ss_rise;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample_evt;
    logic                  shift_evt;
    logic                  word_done;
    logic                  start;
    logic [WordLen-1:0]    rx_next;

    function automatic logic first_bit(input logic [WordLen-1:0] w, input logic lsb_first);
        return lsb_first ? w[0] : w[WordLen-1];
    endfunction

    function automatic logic [WordLen-1:0] shift_out(input logic [WordLen-1:0] w,
                                                     input logic               lsb_first);
        return lsb_first ? (w >> 1) : (w << 1);
    endfunction

    // SS synchronizer resets to the deasserted level so reset release never looks like a select.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], SCLK};
            ss_sync_q   <= {ss_sync_q[SyncStages-2:0], SS};
            mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], MOSI};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
        end
    end

    always_comb begin
        sclk_s     = sclk_sync_q[SyncStages-1];
        ss_s       = ss_sync_q[SyncStages-1];
        mosi_s     = mosi_sync_q[SyncStages-1];
        sclk_rise  = sclk_s & ~sclk_prev_q;
        sclk_fall  = ~sclk_s & sclk_prev_q;
        ss_fall    = ~ss_s & ss_prev_q;
        ss_rise    = ss_s & ~ss_prev_q;
        lead_edge  = cpol_q ? sclk_fall : sclk_rise;
        trail_edge = cpol_q ? sclk_rise : sclk_fall;
        start      = (state_q == ST_IDLE) && ss_fall;
        sample_evt = (state_q == ST_SHIFT) && (cpha_q ? trail_edge : lead_edge);
        // With CPHA=0 the trailing edge at bit 0 would eat the freshly loaded first bit.
        shift_evt  = (state_q == ST_SHIFT) && (cpha_q ? lead_edge : trail_edge)
                     && (cpha_q || (bit_cnt_q != '0));
        word_done  = sample_evt && (bit_cnt_q == CntW'(WordLen - 1));
        rx_next    = order_q ? {mosi_s, rx_q[WordLen-1:1]} : {rx_q[WordLen-2:0], mosi_s};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ss_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (ss_rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        TxBusy = (state_q == ST_SHIFT);
        RxBusy = (bit_cnt_q != '0);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        MISO   = (state_q == ST_SHIFT) ? miso_q : 1'bz;
`else
        MISO   = (state_q == ST_SHIFT) ? miso_q : 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            order_q   <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            flg_q     <= 1'b0;
        end else begin
            flg_q <= 1'b0;
            if (start) begin
                cpol_q    <= CPOL;
                cpha_q    <= CPHA;
                order_q   <= BitOrder;
                tx_q      <= CPHA ? SendData : shift_out(SendData, BitOrder);
                miso_q    <= first_bit(SendData, BitOrder);
                rx_q      <= '0;
                bit_cnt_q <= '0;
            end else if (state_q == ST_SHIFT) begin
                if (sample_evt) begin
                    rx_q <= rx_next;
                    if (word_done) begin
                        rdata_q   <= rx_next;
                        flg_q     <= 1'b1;
                        bit_cnt_q <= '0;
                        tx_q      <= cpha_q ? SendData : shift_out(SendData, order_q);
                        if (!cpha_q) begin
                            miso_q <= first_bit(SendData, order_q);
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CntW'(1);
                    end
                end
                if (shift_evt) begin
                    miso_q <= first_bit(tx_q, order_q);
                    tx_q   <= shift_out(tx_q, order_q);
                end
                if (ss_rise) begin
                    bit_cnt_q <= '0;
                end
            end
        end
    end

    assign ReceivedData = rdata_q;
    assign WordFlg      = flg_q;

endmodule

// File: tb/tb_generic_spi_slave.sv
// Directed bench for generic_spi_slave: a behavioural SPI master drives the bus,
// expected words go into a queue and a WordFlg monitor pops and compares them.
module tb_generic_spi_slave;

    localparam int W = 8;
    localparam int H = 5;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         CPOL = 1'b0;
    logic         CPHA = 1'b0;
    logic         BitOrder = 1'b0;
    logic         SCLK = 1'b0;
    logic         SS = 1'b1;
    logic         MOSI = 1'b0;
    logic         MISO;
    logic [W-1:0] SendData = '0;
    logic [W-1:0] ReceivedData;
    logic         WordFlg;
    logic         RxBusy;
    logic         TxBusy;

    int           n_tests = 0;
    int           n_fail = 0;
    int           n_flags = 0;
    int           n_pushed = 0;
    int           flags_before;
    logic [W-1:0] exp_q[$];

    generic_spi_slave #(.WordLen(W), .SyncStages(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .CPOL         (CPOL),
        .CPHA         (CPHA),
        .BitOrder     (BitOrder),
        .SCLK         (SCLK),
        .SS           (SS),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .SendData     (SendData),
        .ReceivedData (ReceivedData),
        .WordFlg      (WordFlg),
        .RxBusy       (RxBusy),
        .TxBusy       (TxBusy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic mbit(input logic [7:0] a, input logic [7:0] b,
                                  input logic order, input int k);
        logic [7:0] w;
        int         i;
        w = (k < 8) ? a : b;
        i = k % 8;
        return order ? w[i] : w[7-i];
    endfunction

    always @(negedge clk) begin
        if (reset && WordFlg) begin
            n_flags++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wordflg: ReceivedData %h with no word expected", ReceivedData);
            end else begin
                check("rx_word", ReceivedData, exp_q.pop_front());
                check("rxbusy_at_flag", RxBusy, 0);
            end
        end
    end

    // stop_after>0 ends the word after that many sample edges; hold_ss leaves SS low.
    task automatic spi_xfer(input logic cpol, input logic cpha, input logic order,
                            input int nwords, input logic [7:0] m0, input logic [7:0] m1,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input int stop_after, input bit hold_ss);
        logic [7:0] got0;
        logic [7:0] got1;
        int         nbits;
        int         edges;
        int         bi;
        got0  = '0;
        got1  = '0;
        nbits = nwords * 8;
        edges = 0;
        CPOL = cpol;
        CPHA = cpha;
        BitOrder = order;
        SCLK = cpol;
        SendData = s0;
        MOSI = mbit(m0, m1, order, 0);
        waitc(8);
        if (stop_after == 0) begin
            exp_q.push_back(m0);
            n_pushed++;
            if (nwords == 2) begin
                exp_q.push_back(m1);
                n_pushed++;
            end
        end
        SS = 1'b0;
        waitc(4);
        SendData = s1;
        waitc(H - 4);
        for (int k = 0; k < nbits; k++) begin
            bi = order ? (k % 8) : (7 - (k % 8));
            if (!cpha) begin
                if (k < 8) got0[bi] = MISO; else got1[bi] = MISO;
                SCLK = ~cpol;
                edges++;
                waitc(H);
            end else begin
                SCLK = ~cpol;
                MOSI = mbit(m0, m1, order, k);
                waitc(H);
                if (k < 8) got0[bi] = MISO; else got1[bi] = MISO;
                SCLK = cpol;
                edges++;
                waitc(H);
            end
            if (k == 0) begin
                check("rxbusy_mid_word", RxBusy, 1);
                check("txbusy_mid_word", TxBusy, 1);
            end
            if (stop_after != 0 && edges == stop_after) break;
            if (!cpha) begin
                SCLK = cpol;
                if (k + 1 < nbits) MOSI = mbit(m0, m1, order, k + 1);
                waitc(H);
            end
        end
        if (!hold_ss) begin
            SS = 1'b1;
            waitc(4);
            SCLK = cpol;
            waitc(8);
        end
        if (stop_after == 0) begin
            check("miso_word0", got0, s0);
            if (nwords == 2) check("miso_word1", got1, s1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        waitc(3);
        check("reset_miso", MISO, 0);
        check("reset_rdata", ReceivedData, 0);
        check("reset_wordflg", WordFlg, 0);
        check("reset_rxbusy", RxBusy, 0);
        check("reset_txbusy", TxBusy, 0);
        reset = 1'b1;
        waitc(5);
        check("idle_miso", MISO, 0);

        // mode 0, MSB first
        spi_xfer(1'b0, 1'b0, 1'b0, 1, 8'h3C, 8'h00, 8'hA5, 8'hA5, 0, 1'b0);
        check("mode0_rxbusy_after", RxBusy, 0);
        check("mode0_txbusy_after", TxBusy, 0);

        // mode 3, LSB first: MISO bits 1,0,0,0,0,0,0,1
        spi_xfer(1'b1, 1'b1, 1'b1, 1, 8'h0F, 8'h00, 8'h81, 8'h81, 0, 1'b0);
        check("mode3_rdata", ReceivedData, 8'h0F);

        // back-to-back words, SendData updated before the first flag
        spi_xfer(1'b0, 1'b0, 1'b0, 2, 8'hC3, 8'h5A, 8'h11, 8'h22, 0, 1'b0);
        check("b2b_rdata_last", ReceivedData, 8'h5A);

        // abort after 5 sample edges
        spi_xfer(1'b0, 1'b0, 1'b0, 1, 8'h3C, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        flags_before = n_flags;
        spi_xfer(1'b0, 1'b0, 1'b0, 1, 8'hF0, 8'h00, 8'h00, 8'h00, 5, 1'b0);
        check("abort_rdata_kept", ReceivedData, 8'h3C);
        check("abort_no_flag", n_flags - flags_before, 0);
        check("abort_idle_txbusy", TxBusy, 0);
        spi_xfer(1'b0, 1'b0, 1'b0, 1, 8'h99, 8'h00, 8'h6E, 8'h6E, 0, 1'b0);

        // reset in the middle of a mode-1 word
        spi_xfer(1'b0, 1'b1, 1'b0, 1, 8'h6B, 8'h00, 8'hFF, 8'hFF, 3, 1'b1);
        check("pre_reset_txbusy", TxBusy, 1);
        reset = 1'b0;
        #1;
        check("midrst_miso", MISO, 0);
        check("midrst_rdata", ReceivedData, 0);
        check("midrst_wordflg", WordFlg, 0);
        check("midrst_rxbusy", RxBusy, 0);
        check("midrst_txbusy", TxBusy, 0);
        SS = 1'b1;
        SCLK = 1'b0;
        waitc(5);
        reset = 1'b1;
        waitc(5);
        spi_xfer(1'b0, 1'b1, 1'b0, 1, 8'hE7, 8'h00, 8'h5C, 8'h5C, 0, 1'b0);
        check("mode1_rdata", ReceivedData, 8'hE7);

        waitc(20);
        check("scoreboard_empty", exp_q.size(), 0);
        check("flag_count", n_flags, n_pushed);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
